fft_out_reorder: RTL and testbench

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

---
 rtl/fft_out_reorder.sv | 188 ++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// Reorders bit-reversed FFT output into natural bin order, four samples per cycle,
// using two ping-pong banks: one fills while the other drains.
module fft_out_reorder #(
  parameter int NBITS = 10,
  parameter int N     = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_start,
  input  logic [2*NBITS-1:0] fftOut0_up,
  input  logic [2*NBITS-1:0] fftOut0_down,
  input  logic [2*NBITS-1:0] fftOut1_up,
  input  logic [2*NBITS-1:0] fftOut1_down,
  output logic [2*NBITS-1:0] out0,
  output logic [2*NBITS-1:0] out1,
  output logic [2*NBITS-1:0] out2,
  output logic [2*NBITS-1:0] out3,
  output logic               out_valid,
  output logic               out_start,
  output logic               frame_err
);
  localparam int W  = 2 * NBITS;
  localparam int AW = $clog2(N);
  localparam int CW = AW - 2;
  localparam logic [CW-1:0] LAST_CYCLE = CW'(N / 4 - 1);

  typedef enum logic {WR_IDLE, WR_FILL} wrState_e;
  typedef enum logic {RD_IDLE, RD_DRAIN} rdState_e;

  function automatic logic [AW-1:0] bitRev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // Both banks share one array; the bank index is the top address bit.
  logic [W-1:0] mem [0:2*N-1];
  logic [W-1:0] laneIn [4];

  assign laneIn[0] = fftOut0_up;
  assign laneIn[1] = fftOut0_down;
  assign laneIn[2] = fftOut1_up;
  assign laneIn[3] = fftOut1_down;

  // ---------------- write side ----------------
  wrState_e      wrState, wrStateNext;
  logic [CW-1:0] wrCount, wrCountNext;
  logic          wrBank, wrBankNext;
  logic [CW-1:0] curCycle;
  logic          accept, wrLast, frameErrNext;
  logic [AW-1:0] wrAddr [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrState <= WR_IDLE;
      wrCount <= '0;
      wrBank  <= 1'b0;
    end else begin
      wrState <= wrStateNext;
      wrCount <= wrCountNext;
      wrBank  <= wrBankNext;
    end
  end

  // A start while filling restarts the frame at cycle 0 in the same bank.
  always_comb begin
    accept      = in_valid && (in_start || wrState == WR_FILL);
    curCycle    = in_start ? '0 : wrCount;
    wrLast      = accept && (curCycle == LAST_CYCLE);
    wrStateNext = wrState;
    wrCountNext = wrCount;
    wrBankNext  = wrBank;
    if (wrLast) begin
      wrStateNext = WR_IDLE;
      wrCountNext = '0;
      wrBankNext  = ~wrBank;
    end else if (accept) begin
      wrStateNext = WR_FILL;
      wrCountNext = curCycle + 1'b1;
    end
  end

  always_comb begin
    frameErrNext = in_valid &&
                   ((wrState == WR_IDLE && !in_start) ||
                    (wrState == WR_FILL && in_start && wrCount != '0));
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_wrAddr
    assign wrAddr[gi] = bitRev({curCycle, 2'(gi)});
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < 4; l++) mem[{wrBank, wrAddr[l]}] <= laneIn[l];
    end
  end

  // ---------------- read side ----------------
  rdState_e      rdState, rdStateNext;
  logic [CW-1:0] rdCount, rdCountNext;
  logic          rdBank, rdBankNext;
  logic [1:0]    bankFull, bankFullNext;
  logic          drainEnd, loadValid, loadStart;
  logic [AW:0]   rdAddr [4];
  logic [W-1:0]  rdData [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdState  <= RD_IDLE;
      rdCount  <= '0;
      rdBank   <= 1'b0;
      bankFull <= 2'b00;
    end else begin
      rdState  <= rdStateNext;
      rdCount  <= rdCountNext;
      rdBank   <= rdBankNext;
      bankFull <= bankFullNext;
    end
  end

  // Drain starts on the same edge the bank fills, so j=0 appears one cycle later.
  always_comb begin
    drainEnd     = (rdState == RD_DRAIN) && (rdCount == LAST_CYCLE);
    rdStateNext  = rdState;
    rdCountNext  = rdCount;
    rdBankNext   = rdBank;
    bankFullNext = bankFull;
    if (drainEnd) bankFullNext[rdBank] = 1'b0;
    if (wrLast)   bankFullNext[wrBank] = 1'b1;
    case (rdState)
      RD_IDLE: begin
        if (wrLast) begin
          rdStateNext = RD_DRAIN;
          rdCountNext = '0;
          rdBankNext  = wrBank;
        end
      end
      RD_DRAIN: begin
        if (!drainEnd) begin
          rdCountNext = rdCount + 1'b1;
        end else if (bankFull[~rdBank] || (wrLast && wrBank != rdBank)) begin
          rdCountNext = '0;
          rdBankNext  = ~rdBank;
        end else begin
          rdStateNext = RD_IDLE;
          rdCountNext = '0;
        end
      end
      default: rdStateNext = RD_IDLE;
    endcase
  end

  // Bins written on this very edge are forwarded straight from the lane inputs.
  always_comb begin
    loadValid = (rdStateNext == RD_DRAIN);
    loadStart = loadValid && (rdCountNext == '0);
    for (int l = 0; l < 4; l++) begin
      rdAddr[l] = {rdBankNext, rdCountNext, 2'(l)};
      rdData[l] = mem[rdAddr[l]];
      for (int w = 0; w < 4; w++) begin
        if (accept && {wrBank, wrAddr[w]} == rdAddr[l]) rdData[l] = laneIn[w];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out0      <= loadValid ? rdData[0] : '0;
      out1      <= loadValid ? rdData[1] : '0;
      out2      <= loadValid ? rdData[2] : '0;
      out3      <= loadValid ? rdData[3] : '0;
      out_valid <= loadValid;
      out_start <= loadStart;
      frame_err <= frameErrNext;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomized self-checking bench for fft_out_reorder; the reference model maps each
// output bin back to its arrival index by arithmetic bit reversal.
module tb_fft_out_reorder;
  localparam int NBITS = 10;
  localparam int N     = 128;
  localparam int W     = 2 * NBITS;
  localparam int NC    = N / 4;
  localparam int LOGSZ = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_start = 1'b0;
  logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [W-1:0] out0, out1, out2, out3;
  logic out_valid, out_start, frame_err;

  fft_out_reorder #(.NBITS(NBITS), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start),
    .fftOut0_up(in0), .fftOut0_down(in1), .fftOut1_up(in2), .fftOut1_down(in3),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .out_start(out_start), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           logV [LOGSZ];
  logic           logS [LOGSZ];
  logic           logE [LOGSZ];
  logic [4*W-1:0] logD [LOGSZ];
  always @(negedge clk) begin
    if (cyc < LOGSZ) begin
      logV[cyc] = out_valid;
      logS[cyc] = out_start;
      logE[cyc] = frame_err;
      logD[cyc] = {out0, out1, out2, out3};
    end
  end

  int nChecks = 0;
  int nFail   = 0;
  logic [W-1:0] frames [4][N];

  function automatic int brev(input int a);
    int r = 0;
    int v = a;
    for (int i = 0; i < $clog2(N); i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // Output beat j of frame f carries bins 4j..4j+3, each taken from arrival brev(bin).
  function automatic logic [4*W-1:0] expBeat(input int f, input int j);
    return {frames[f][brev(4*j)], frames[f][brev(4*j+1)],
            frames[f][brev(4*j+2)], frames[f][brev(4*j+3)]};
  endfunction

  task automatic make_ramp(input int f, input int off);
    for (int a = 0; a < N; a++) frames[f][a] = W'(((a + off) % 1024) * 1024);
  endtask

  task automatic make_rand(input int f);
    for (int a = 0; a < N; a++) frames[f][a] = W'($urandom);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // gapMode: 0 continuous, 1 idle cycle between every valid cycle, 2 random idles
  task automatic drive_frame(input int f, input int gapMode, output int firstCyc, output int lastCyc);
    firstCyc = 0;
    lastCyc  = 0;
    for (int c = 0; c < NC; c++) begin
      if ((gapMode == 1 && c > 0) || (gapMode == 2 && $urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_start = 1'($urandom_range(0, 1));
        in0 = W'($urandom); in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_start = (c == 0);
      in0 = frames[f][4*c];   in1 = frames[f][4*c+1];
      in2 = frames[f][4*c+2]; in3 = frames[f][4*c+3];
      if (c == 0) firstCyc = cyc;
      lastCyc = cyc;
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_start = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    in_start = 1'b0;
    @(negedge clk);
    nChecks++;
    if (out_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    nChecks++;
    if (out_start !== 1'b0) begin nFail++; $display("FAIL reset_start: got %b want 0", out_start); end
    nChecks++;
    if (frame_err !== 1'b0) begin nFail++; $display("FAIL reset_err: got %b want 0", frame_err); end
    nChecks++;
    if ({out0, out1, out2, out3} !== '0) begin
      nFail++; $display("FAIL reset_data: got %h want 0", {out0, out1, out2, out3});
    end
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_ramp();
    int fc, lc, t, errs;
    int firstR[4] = '{0, 64, 32, 96};
    int lastR[4]  = '{31, 95, 63, 127};
    make_ramp(0, 0);
    drive_frame(0, 0, fc, lc);
    idle(40);
    nChecks++;
    if (logV[lc] !== 1'b0) begin nFail++; $display("FAIL ramp_early: valid=%b at last input cycle, want 0", logV[lc]); end
    for (int j = 0; j < NC; j++) begin
      t = lc + 1 + j;
      nChecks++;
      if (logV[t] !== 1'b1 || logS[t] !== (j == 0) || logD[t] !== expBeat(0, j)) begin
        nFail++;
        $display("FAIL ramp_beat %0d: valid=%b start=%b data=%h, want valid=1 start=%b data=%h",
                 j, logV[t], logS[t], logD[t], (j == 0), expBeat(0, j));
      end
    end
    for (int l = 0; l < 4; l++) begin
      nChecks++;
      if (int'(logD[lc+1][(4-l)*W-1 -: NBITS]) != firstR[l]) begin
        nFail++; $display("FAIL ramp_first lane %0d: real=%0d want %0d", l, logD[lc+1][(4-l)*W-1 -: NBITS], firstR[l]);
      end
      nChecks++;
      if (int'(logD[lc+NC][(4-l)*W-1 -: NBITS]) != lastR[l]) begin
        nFail++; $display("FAIL ramp_last lane %0d: real=%0d want %0d", l, logD[lc+NC][(4-l)*W-1 -: NBITS], lastR[l]);
      end
    end
    t = lc + 1 + NC;
    nChecks++;
    if (logV[t] !== 1'b0 || logD[t] !== '0) begin
      nFail++; $display("FAIL ramp_after: valid=%b data=%h, want 0 and 0", logV[t], logD[t]);
    end
    errs = 0;
    for (int i = fc; i <= lc + NC + 1; i++) if (logE[i] !== 1'b0) errs++;
    nChecks++;
    if (errs != 0) begin nFail++; $display("FAIL ramp_err: %0d frame_err cycles, want 0", errs); end
    $display("test_ramp done: out_start at cycle %0d", lc + 1);
  endtask

  task automatic test_back_to_back();
    int fc, lc1, lc2, lc3, t, f, j;
    make_ramp(1, 0);
    make_ramp(2, 128);
    make_ramp(3, 256);
    drive_frame(1, 0, fc, lc1);
    drive_frame(2, 0, fc, lc2);
    drive_frame(3, 0, fc, lc3);
    idle(40);
    for (int k = 0; k < 3 * NC; k++) begin
      t = lc1 + 1 + k;
      f = 1 + k / NC;
      j = k % NC;
      nChecks++;
      if (logV[t] !== 1'b1 || logS[t] !== (j == 0) || logD[t] !== expBeat(f, j)) begin
        nFail++;
        $display("FAIL b2b_beat %0d: valid=%b start=%b data=%h, want valid=1 start=%b data=%h",
                 k, logV[t], logS[t], logD[t], (j == 0), expBeat(f, j));
      end
    end
    nChecks++;
    if (logV[lc1 + 1 + 3*NC] !== 1'b0) begin nFail++; $display("FAIL b2b_after: valid=%b want 0", logV[lc1 + 1 + 3*NC]); end
    $display("test_back_to_back done: frames ended at %0d %0d %0d", lc1, lc2, lc3);
  endtask

  task automatic test_gaps();
    int fc, lc, t;
    make_ramp(0, 0);
    drive_frame(0, 1, fc, lc);
    idle(40);
    for (int j = 0; j < NC; j++) begin
      t = lc + 1 + j;
      nChecks++;
      if (logV[t] !== 1'b1 || logS[t] !== (j == 0) || logD[t] !== expBeat(0, j)) begin
        nFail++;
        $display("FAIL gaps_beat %0d: valid=%b start=%b data=%h, want valid=1 start=%b data=%h",
                 j, logV[t], logS[t], logD[t], (j == 0), expBeat(0, j));
      end
    end
    nChecks++;
    if (logV[lc] !== 1'b0 || logV[lc + 1 + NC] !== 1'b0) begin
      nFail++; $display("FAIL gaps_edges: valid before=%b after=%b, want 0 0", logV[lc], logV[lc + 1 + NC]);
    end
    $display("test_gaps done: input span %0d cycles", lc - fc + 1);
  endtask

  task automatic test_restart();
    int fc, lc, t, early;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_start = (c == 0);
      in0 = W'($urandom); in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
    end
    make_rand(1);
    drive_frame(1, 0, fc, lc);
    idle(40);
    nChecks++;
    if (logE[fc] !== 1'b0 || logE[fc+1] !== 1'b1 || logE[fc+2] !== 1'b0) begin
      nFail++; $display("FAIL restart_err: pulse %b%b%b, want 010", logE[fc], logE[fc+1], logE[fc+2]);
    end
    early = 0;
    for (int i = fc - 10; i <= lc; i++) if (logV[i] !== 1'b0) early++;
    nChecks++;
    if (early != 0) begin nFail++; $display("FAIL restart_early: %0d valid cycles before frame end, want 0", early); end
    for (int j = 0; j < NC; j++) begin
      t = lc + 1 + j;
      nChecks++;
      if (logV[t] !== 1'b1 || logS[t] !== (j == 0) || logD[t] !== expBeat(1, j)) begin
        nFail++;
        $display("FAIL restart_beat %0d: valid=%b start=%b data=%h, want valid=1 start=%b data=%h",
                 j, logV[t], logS[t], logD[t], (j == 0), expBeat(1, j));
      end
    end
    $display("test_restart done: restart at cycle %0d", fc);
  endtask

  task automatic test_reset_mid_drain();
    int fc, lc, t, stale, relCyc;
    make_rand(0);
    drive_frame(0, 0, fc, lc);
    @(negedge clk);
    in_valid = 1'b0;
    in_start = 1'b0;
    while (cyc < lc + 6) @(negedge clk);
    nChecks++;
    if (out_valid !== 1'b1 || {out0, out1, out2, out3} !== expBeat(0, 5)) begin
      nFail++; $display("FAIL middrain_pre: valid=%b data=%h, want 1 %h", out_valid, {out0, out1, out2, out3}, expBeat(0, 5));
    end
    rst = 1'b0;
    #1;
    nChecks++;
    if (out_valid !== 1'b0 || out_start !== 1'b0 || frame_err !== 1'b0 || {out0, out1, out2, out3} !== '0) begin
      nFail++; $display("FAIL middrain_reset: valid=%b start=%b err=%b data=%h, want all 0",
                        out_valid, out_start, frame_err, {out0, out1, out2, out3});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    relCyc = cyc;
    repeat (60) @(negedge clk);
    stale = 0;
    for (int i = relCyc; i <= cyc; i++) if (logV[i] !== 1'b0) stale++;
    nChecks++;
    if (stale != 0) begin nFail++; $display("FAIL middrain_stale: %0d valid cycles after release, want 0", stale); end
    make_rand(1);
    drive_frame(1, 0, fc, lc);
    idle(40);
    for (int j = 0; j < NC; j++) begin
      t = lc + 1 + j;
      nChecks++;
      if (logV[t] !== 1'b1 || logS[t] !== (j == 0) || logD[t] !== expBeat(1, j)) begin
        nFail++;
        $display("FAIL middrain_beat %0d: valid=%b start=%b data=%h, want valid=1 start=%b data=%h",
                 j, logV[t], logS[t], logD[t], (j == 0), expBeat(1, j));
      end
    end
    $display("test_reset_mid_drain done: reset released at cycle %0d", relCyc);
  endtask

  task automatic test_stray_valid();
    int t0, seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_start = 1'b0;
    in0 = W'($urandom); in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
    t0 = cyc;
    idle(40);
    nChecks++;
    if (logE[t0+1] !== 1'b1 || logE[t0+2] !== 1'b0) begin
      nFail++; $display("FAIL stray_err: pulse %b%b, want 10", logE[t0+1], logE[t0+2]);
    end
    seen = 0;
    for (int i = t0; i <= cyc; i++) if (logV[i] !== 1'b0) seen++;
    nChecks++;
    if (seen != 0) begin nFail++; $display("FAIL stray_output: %0d valid cycles, want 0", seen); end
    $display("test_stray_valid done: stray at cycle %0d", t0);
  endtask

  task automatic test_random();
    int fc, lcs[4], t;
    for (int f = 0; f < 4; f++) make_rand(f);
    for (int f = 0; f < 4; f++) drive_frame(f, 2, fc, lcs[f]);
    idle(40);
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < NC; j++) begin
        t = lcs[f] + 1 + j;
        nChecks++;
        if (logV[t] !== 1'b1 || logS[t] !== (j == 0) || logD[t] !== expBeat(f, j) || logE[t] !== 1'b0) begin
          nFail++;
          $display("FAIL random_f%0d_beat %0d: valid=%b start=%b err=%b data=%h, want valid=1 start=%b err=0 data=%h",
                   f, j, logV[t], logS[t], logE[t], logD[t], (j == 0), expBeat(f, j));
        end
      end
    end
    $display("test_random done: frames ended at %0d %0d %0d %0d", lcs[0], lcs[1], lcs[2], lcs[3]);
  endtask

  initial begin
    test_reset();
    idle(3);
    test_ramp();
    test_back_to_back();
    test_gaps();
    test_restart();
    test_reset_mid_drain();
    test_stray_valid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
